// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Requester handshakes and register-file write-port bundle for
//               the write-back arbiter. Signal prefixes are from the
//               arbiter's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Requester 0 (ALU)
    logic                   i_valid0;
    logic                   o_ready0;
    logic [ADDR_W-1:0]      i_addr0;
    logic [DATA_W-1:0]      i_data0;
    // Requester 1 (load unit)
    logic                   i_valid1;
    logic                   o_ready1;
    logic [ADDR_W-1:0]      i_addr1;
    logic [DATA_W-1:0]      i_data1;
    // Register-file write port and hazard status
    logic                   o_reg_write;
    logic [ADDR_W-1:0]      o_write_addr;
    logic [DATA_W-1:0]      o_write_data;
    logic [2**ADDR_W-1:0]   o_pend_mask;
    logic                   o_idle;

    modport slave (
        input  i_valid0, i_addr0, i_data0,
        input  i_valid1, i_addr1, i_data1,
        output o_ready0, o_ready1,
        output o_reg_write, o_write_addr, o_write_data, o_pend_mask, o_idle
    );

    modport master (
        output i_valid0, i_addr0, i_data0,
        output i_valid1, i_addr1, i_data1,
        input  o_ready0, o_ready1,
        input  o_reg_write, o_write_addr, o_write_data, o_pend_mask, o_idle
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register-file write port between the ALU (req 0)
//               and the load unit (req 1). Each requester has a one-entry
//               holding buffer; one buffered write is granted per cycle into
//               a registered RegWrite/WriteAddr/WriteData stage. Publishes a
//               pending-write mask for RAW hazard stalls.
//               Build option WB_ARB_RR_EN: round-robin conflict resolution;
//               when undefined, requester 1 always wins a conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int c_NREG = 2**ADDR_W;

    logic              r_full0, r_full1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic [DATA_W-1:0] r_data0, r_data1;
    logic              r_last_gnt;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_addr;
    logic [DATA_W-1:0] r_write_data;

    logic              w_gnt0, w_gnt1;
    logic              w_ready0, w_ready1;
    logic              w_load0, w_load1;
    logic [c_NREG-1:0] w_pend_mask;

    // Grant selection from buffer occupancy; conflicts resolved by build option
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_full0 && r_full1) begin
`ifdef WB_ARB_RR_EN
            // The requester that did not win last time gets the port
            w_gnt0 = r_last_gnt;
            w_gnt1 = ~r_last_gnt;
`else
            w_gnt1 = 1'b1;
`endif
        end else begin
            w_gnt0 = r_full0;
            w_gnt1 = r_full1;
        end
    end

    // A buffer draining this cycle may be refilled on the same edge
    assign w_ready0 = ~r_full0 | w_gnt0;
    assign w_ready1 = ~r_full1 | w_gnt1;

    // Writes to register 0 are acknowledged but never stored
    assign w_load0 = bus.i_valid0 & w_ready0 & (|bus.i_addr0);
    assign w_load1 = bus.i_valid1 & w_ready1 & (|bus.i_addr1);

    // Requester 0 holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full0 <= 1'b0;
            r_addr0 <= '0;
            r_data0 <= '0;
        end else if (w_load0) begin
            r_full0 <= 1'b1;
            r_addr0 <= bus.i_addr0;
            r_data0 <= bus.i_data0;
        end else if (w_gnt0) begin
            r_full0 <= 1'b0;
        end
    end

    // Requester 1 holding buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full1 <= 1'b0;
            r_addr1 <= '0;
            r_data1 <= '0;
        end else if (w_load1) begin
            r_full1 <= 1'b1;
            r_addr1 <= bus.i_addr1;
            r_data1 <= bus.i_data1;
        end else if (w_gnt1) begin
            r_full1 <= 1'b0;
        end
    end

    // Output stage: one-cycle strobe per grant, address/data hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write  <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_last_gnt   <= 1'b1;
        end else begin
            r_reg_write <= w_gnt0 | w_gnt1;
            if (w_gnt0) begin
                r_write_addr <= r_addr0;
                r_write_data <= r_data0;
                r_last_gnt   <= 1'b0;
            end else if (w_gnt1) begin
                r_write_addr <= r_addr1;
                r_write_data <= r_data1;
                r_last_gnt   <= 1'b1;
            end
        end
    end

    // Pending-write mask: every buffered or in-flight destination register
    always_comb begin
        w_pend_mask = '0;
        if (r_full0)     w_pend_mask[r_addr0]      = 1'b1;
        if (r_full1)     w_pend_mask[r_addr1]      = 1'b1;
        if (r_reg_write) w_pend_mask[r_write_addr] = 1'b1;
    end

    assign bus.o_ready0     = w_ready0;
    assign bus.o_ready1     = w_ready1;
    assign bus.o_reg_write  = r_reg_write;
    assign bus.o_write_addr = r_write_addr;
    assign bus.o_write_data = r_write_data;
    assign bus.o_pend_mask  = w_pend_mask;
    assign bus.o_idle       = ~r_full0 & ~r_full1 & ~r_reg_write;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter. Inputs
//               are driven and outputs sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_valid0 = 1'b0;
        bus.i_addr0  = '0;
        bus.i_data0  = '0;
        bus.i_valid1 = 1'b0;
        bus.i_addr1  = '0;
        bus.i_data1  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_reg_write !== 1'b0 || bus.o_write_addr !== 5'd0 || bus.o_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: got rw=%b addr=%0d data=%h, want 0/0/0", bus.o_reg_write, bus.o_write_addr, bus.o_write_data);
        end
        checks++;
        if (bus.o_pend_mask !== 32'd0 || bus.o_idle !== 1'b1 || bus.o_ready0 !== 1'b1 || bus.o_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got pend=%h idle=%b rdy0=%b rdy1=%b, want 0/1/1/1", bus.o_pend_mask, bus.o_idle, bus.o_ready0, bus.o_ready1);
        end
        step();
        step();
        rst_n = 1'b1;
        step();

        // Mid-stream reset with both buffers full and a write in flight
        bus.i_valid0 = 1'b1; bus.i_addr0 = 5'd3; bus.i_data0 = 32'h0000_0A03;
        bus.i_valid1 = 1'b1; bus.i_addr1 = 5'd7; bus.i_data1 = 32'h0000_0B07;
        step();
        step();
        checks++;
        if (bus.o_reg_write !== 1'b1 || bus.o_idle !== 1'b0) begin
            errors++;
            $display("FAIL reset_prefill: got rw=%b idle=%b, want 1/0", bus.o_reg_write, bus.o_idle);
        end
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_reg_write !== 1'b0 || bus.o_pend_mask !== 32'd0 || bus.o_ready0 !== 1'b1 || bus.o_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got rw=%b pend=%h rdy0=%b rdy1=%b, want 0/0/1/1", bus.o_reg_write, bus.o_pend_mask, bus.o_ready0, bus.o_ready1);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.o_reg_write !== 1'b0 || bus.o_idle !== 1'b1) begin
                errors++;
                $display("FAIL reset_stale c%0d: got rw=%b idle=%b, want 0/1", i, bus.o_reg_write, bus.o_idle);
            end
        end
    endtask

    task automatic test_single_write();
        bus.i_valid0 = 1'b1; bus.i_addr0 = 5'd5; bus.i_data0 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.o_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b, want 1", bus.o_ready0);
        end
        step();
        clear_inputs();
        checks++;
        if (bus.o_reg_write !== 1'b0 || bus.o_pend_mask !== 32'h0000_0020 || bus.o_idle !== 1'b0) begin
            errors++;
            $display("FAIL single_buffered: got rw=%b pend=%h idle=%b, want 0/00000020/0", bus.o_reg_write, bus.o_pend_mask, bus.o_idle);
        end
        step();
        checks++;
        if (bus.o_reg_write !== 1'b1 || bus.o_write_addr !== 5'd5 || bus.o_write_data !== 32'hDEAD_BEEF || bus.o_pend_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL single_write: got rw=%b addr=%0d data=%h pend=%h, want 1/5/deadbeef/00000020", bus.o_reg_write, bus.o_write_addr, bus.o_write_data, bus.o_pend_mask);
        end
        step();
        checks++;
        if (bus.o_reg_write !== 1'b0 || bus.o_pend_mask !== 32'd0 || bus.o_idle !== 1'b1 || bus.o_write_addr !== 5'd5 || bus.o_write_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_after: got rw=%b pend=%h idle=%b addr=%0d data=%h, want 0/0/1/5/deadbeef", bus.o_reg_write, bus.o_pend_mask, bus.o_idle, bus.o_write_addr, bus.o_write_data);
        end
    endtask

    task automatic test_conflict();
        logic [4:0]  exp_addr;
        logic        exp_rdy0;
        logic        exp_rdy1;
        bit          drained;
        bus.i_valid0 = 1'b1; bus.i_addr0 = 5'd3; bus.i_data0 = 32'h0000_0A03;
        bus.i_valid1 = 1'b1; bus.i_addr1 = 5'd7; bus.i_data1 = 32'h0000_0B07;
        for (int i = 1; i <= 8; i++) begin
            #1;
`ifdef WB_ARB_RR_EN
            exp_rdy0 = (i == 1) ? 1'b1 : ((i % 2) == 0);
            exp_rdy1 = (i == 1) ? 1'b1 : ((i % 2) == 1);
`else
            exp_rdy0 = (i == 1);
            exp_rdy1 = 1'b1;
`endif
            checks++;
            if (bus.o_ready0 !== exp_rdy0 || bus.o_ready1 !== exp_rdy1) begin
                errors++;
                $display("FAIL conflict_ready c%0d: got %b%b, want %b%b", i, bus.o_ready0, bus.o_ready1, exp_rdy0, exp_rdy1);
            end
            step();
            if (i >= 2) begin
`ifdef WB_ARB_RR_EN
                exp_addr = ((i % 2) == 0) ? 5'd3 : 5'd7;
`else
                exp_addr = 5'd7;
`endif
                checks++;
                if (bus.o_reg_write !== 1'b1 || bus.o_write_addr !== exp_addr ||
                    bus.o_write_data !== ((exp_addr == 5'd3) ? 32'h0000_0A03 : 32'h0000_0B07)) begin
                    errors++;
                    $display("FAIL conflict_grant c%0d: got rw=%b addr=%0d data=%h, want 1/%0d", i, bus.o_reg_write, bus.o_write_addr, bus.o_write_data, exp_addr);
                end
            end
        end
`ifndef WB_ARB_RR_EN
        // Load unit stops; its last buffered write drains before the ALU's
        bus.i_valid1 = 1'b0;
        #1;
        checks++;
        if (bus.o_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL conflict_fixed_wait: got rdy0=%b, want 0", bus.o_ready0);
        end
        step();
        checks++;
        if (bus.o_ready0 !== 1'b1 || bus.o_write_addr !== 5'd7) begin
            errors++;
            $display("FAIL conflict_fixed_release: got rdy0=%b addr=%0d, want 1/7", bus.o_ready0, bus.o_write_addr);
        end
        bus.i_valid0 = 1'b0;
        step();
        checks++;
        if (bus.o_reg_write !== 1'b1 || bus.o_write_addr !== 5'd3) begin
            errors++;
            $display("FAIL conflict_fixed_alu: got rw=%b addr=%0d, want 1/3", bus.o_reg_write, bus.o_write_addr);
        end
`endif
        clear_inputs();
        drained = 1'b0;
        for (int i = 0; i < 6 && !drained; i++) begin
            step();
            if (bus.o_idle === 1'b1) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL conflict_drain: got idle=%b, want 1 within 6 cycles", bus.o_idle);
        end
    endtask

    task automatic test_addr_zero();
        bus.i_valid1 = 1'b1; bus.i_addr1 = 5'd0; bus.i_data1 = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.o_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: got %b, want 1", bus.o_ready1);
        end
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.o_reg_write !== 1'b0 || bus.o_pend_mask !== 32'd0 || bus.o_idle !== 1'b1) begin
                errors++;
                $display("FAIL zero_dropped c%0d: got rw=%b pend=%h idle=%b, want 0/0/1", i, bus.o_reg_write, bus.o_pend_mask, bus.o_idle);
            end
            step();
        end
    endtask

    task automatic test_same_register();
        logic [31:0] first_data;
        bus.i_valid0 = 1'b1; bus.i_addr0 = 5'd9; bus.i_data0 = 32'h0000_0011;
        bus.i_valid1 = 1'b1; bus.i_addr1 = 5'd9; bus.i_data1 = 32'h0000_0022;
        step();
        clear_inputs();
        checks++;
        if (bus.o_pend_mask !== 32'h0000_0200 || bus.o_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL same_accept: got pend=%h rw=%b, want 00000200/0", bus.o_pend_mask, bus.o_reg_write);
        end
        step();
        first_data = bus.o_write_data;
        checks++;
        if (bus.o_reg_write !== 1'b1 || bus.o_write_addr !== 5'd9 || bus.o_pend_mask !== 32'h0000_0200) begin
            errors++;
            $display("FAIL same_first: got rw=%b addr=%0d pend=%h, want 1/9/00000200", bus.o_reg_write, bus.o_write_addr, bus.o_pend_mask);
        end
        step();
        checks++;
        if (bus.o_reg_write !== 1'b1 || bus.o_pend_mask !== 32'h0000_0200 || (first_data ^ bus.o_write_data) !== 32'h0000_0033) begin
            errors++;
            $display("FAIL same_second: got rw=%b pend=%h data=%h/%h, want 1/00000200 and 11,22 in some order", bus.o_reg_write, bus.o_pend_mask, first_data, bus.o_write_data);
        end
        step();
        checks++;
        if (bus.o_pend_mask !== 32'd0 || bus.o_idle !== 1'b1) begin
            errors++;
            $display("FAIL same_clear: got pend=%h idle=%b, want 0/1", bus.o_pend_mask, bus.o_idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_mask;
        for (int i = 1; i <= 8; i++) begin
            bus.i_valid0 = 1'b1;
            bus.i_addr0  = 5'(i);
            bus.i_data0  = 32'h100 + 32'(i);
            #1;
            checks++;
            if (bus.o_ready0 !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready c%0d: got %b, want 1", i, bus.o_ready0);
            end
            step();
            if (i >= 2) begin
                exp_mask = (32'd1 << i) | (32'd1 << (i - 1));
                checks++;
                if (bus.o_reg_write !== 1'b1 || bus.o_write_addr !== 5'(i - 1) ||
                    bus.o_write_data !== 32'h100 + 32'(i - 1) || bus.o_pend_mask !== exp_mask) begin
                    errors++;
                    $display("FAIL b2b_write c%0d: got rw=%b addr=%0d data=%h pend=%h, want 1/%0d/%h/%h", i, bus.o_reg_write, bus.o_write_addr, bus.o_write_data, bus.o_pend_mask, i - 1, 32'h100 + 32'(i - 1), exp_mask);
                end
            end
        end
        clear_inputs();
        step();
        checks++;
        if (bus.o_reg_write !== 1'b1 || bus.o_write_addr !== 5'd8 || bus.o_write_data !== 32'h108) begin
            errors++;
            $display("FAIL b2b_last: got rw=%b addr=%0d data=%h, want 1/8/00000108", bus.o_reg_write, bus.o_write_addr, bus.o_write_data);
        end
        step();
        checks++;
        if (bus.o_reg_write !== 1'b0 || bus.o_idle !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: got rw=%b idle=%b, want 0/1", bus.o_reg_write, bus.o_idle);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_write();
        test_conflict();
        test_addr_zero();
        test_same_register();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want completion before 100000 ns");
        $fatal(1);
    end
endmodule
`default_nettype wire
